// File: rtl/taxi_pkg.sv
// Shared constants, types and grid helpers for the Taxi-v3 environment core.
package taxi_pkg;

  localparam int unsigned GRID   = 5;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned PASS_W = 3;
  localparam int unsigned DEST_W = 2;
  localparam int unsigned REW_W  = 6;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LFSR_W = 16;

  localparam logic [ROW_W-1:0]  GRID_MAX     = ROW_W'(GRID - 1);
  localparam logic [PASS_W-1:0] PASS_IN_TAXI = 3'd4;

  localparam logic [2:0] ACT_SOUTH   = 3'd0;
  localparam logic [2:0] ACT_NORTH   = 3'd1;
  localparam logic [2:0] ACT_EAST    = 3'd2;
  localparam logic [2:0] ACT_WEST    = 3'd3;
  localparam logic [2:0] ACT_PICKUP  = 3'd4;
  localparam logic [2:0] ACT_DROPOFF = 3'd5;

  localparam logic signed [REW_W-1:0] R_STEP    = -6'sd1;
  localparam logic signed [REW_W-1:0] R_ILLEGAL = -6'sd10;
  localparam logic signed [REW_W-1:0] R_GOAL    = 6'sd20;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_RUN, S_END} state_t;

  // Landmarks R, G, Y, B in index order.
  function automatic logic [ROW_W-1:0] land_row(input logic [DEST_W-1:0] idx);
    return (idx[1]) ? 3'd4 : 3'd0;
  endfunction

  function automatic logic [ROW_W-1:0] land_col(input logic [DEST_W-1:0] idx);
    logic [ROW_W-1:0] c;
    case (idx)
      2'd0:    c = 3'd0;
      2'd1:    c = 3'd4;
      2'd2:    c = 3'd0;
      default: c = 3'd3;
    endcase
    return c;
  endfunction

  // Landmark index under the taxi, or PASS_IN_TAXI when not on one.
  function automatic logic [PASS_W-1:0] landmark_of(input logic [ROW_W-1:0] row,
                                                     input logic [ROW_W-1:0] col);
    logic [PASS_W-1:0] lm;
    lm = PASS_IN_TAXI;
    for (int i = 0; i < 4; i++) begin
      if (row == land_row(DEST_W'(i)) && col == land_col(DEST_W'(i))) lm = PASS_W'(i);
    end
    return lm;
  endfunction

  function automatic logic east_wall(input logic [ROW_W-1:0] row, input logic [ROW_W-1:0] col);
    return (col == GRID_MAX) || (row <= 3'd1 && col == 3'd1) ||
           (row >= 3'd3 && (col == 3'd0 || col == 3'd2));
  endfunction

  function automatic logic west_wall(input logic [ROW_W-1:0] row, input logic [ROW_W-1:0] col);
    return (col == 3'd0) || (row <= 3'd1 && col == 3'd2) ||
           (row >= 3'd3 && (col == 3'd1 || col == 3'd3));
  endfunction

endpackage

// File: rtl/taxi_env_step_if.sv
// Load/start/action inputs and episode-state/step-result outputs of the environment.
interface taxi_env_step_if;
  import taxi_pkg::*;

  logic                load_valid;
  logic [ROW_W-1:0]    load_row;
  logic [ROW_W-1:0]    load_col;
  logic [PASS_W-1:0]   load_pass;
  logic [DEST_W-1:0]   load_dest;
  logic                start;
  logic                act_valid;
  logic [2:0]          act;
  logic                act_ready;
  logic [ROW_W-1:0]    taxi_row;
  logic [ROW_W-1:0]    taxi_col;
  logic [PASS_W-1:0]   pass_loc;
  logic [DEST_W-1:0]   dest_idx;
  logic                step_valid;
  logic [REW_W-1:0]    reward;
  logic                done;
  logic                truncated;
  logic [CNT_W-1:0]    step_count;

  modport master (
    output load_valid, load_row, load_col, load_pass, load_dest, start, act_valid, act,
    input  act_ready, taxi_row, taxi_col, pass_loc, dest_idx, step_valid, reward,
           done, truncated, step_count
  );

  modport slave (
    input  load_valid, load_row, load_col, load_pass, load_dest, start, act_valid, act,
    output act_ready, taxi_row, taxi_col, pass_loc, dest_idx, step_valid, reward,
           done, truncated, step_count
  );
endinterface

// File: rtl/taxi_lfsr.sv
// Free-running 16-bit Galois LFSR (mask 16'hB400) used for random episode starts.
module taxi_lfsr
  import taxi_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] o_lfsr
);
  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= SEED;
    else     r_lfsr <= {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/taxi_env_step.sv
// Taxi-v3 environment core: holds episode state and applies one action per handshake.
module taxi_env_step
  import taxi_pkg::*;
#(
  parameter int unsigned       MAX_STEPS = 200,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  taxi_env_step_if.slave  bus
);
  state_t                   r_state, w_state_nxt;
  logic [ROW_W-1:0]         r_row, w_row_nxt, r_col, w_col_nxt;
  logic [PASS_W-1:0]        r_pass, w_pass_nxt;
  logic [DEST_W-1:0]        r_dest, w_dest_nxt;
  logic                     r_step_valid, w_step_valid_nxt;
  logic signed [REW_W-1:0]  r_reward, w_reward_nxt;
  logic                     r_done, w_done_nxt, r_trunc, w_trunc_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [LFSR_W-1:0]        w_lfsr;
  logic                     w_gen_ok;
  logic [PASS_W-1:0]        w_land;
  logic                     w_unused_lfsr;

  taxi_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .o_lfsr(w_lfsr));

  assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:10];
  assign w_gen_ok  = (w_lfsr[2:0] < ROW_W'(GRID)) && (w_lfsr[5:3] < ROW_W'(GRID)) &&
                     (w_lfsr[7:6] != w_lfsr[9:8]);
  assign w_land    = landmark_of(r_row, r_col);
  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_pass       <= '0;
      r_dest       <= '0;
      r_step_valid <= 1'b0;
      r_reward     <= '0;
      r_done       <= 1'b0;
      r_trunc      <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_pass       <= w_pass_nxt;
      r_dest       <= w_dest_nxt;
      r_step_valid <= w_step_valid_nxt;
      r_reward     <= w_reward_nxt;
      r_done       <= w_done_nxt;
      r_trunc      <= w_trunc_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // Next state: load beats start beats an accepted action.
  always_comb begin
    w_state_nxt      = r_state;
    w_row_nxt        = r_row;
    w_col_nxt        = r_col;
    w_pass_nxt       = r_pass;
    w_dest_nxt       = r_dest;
    w_step_valid_nxt = 1'b0;
    w_reward_nxt     = r_reward;
    w_done_nxt       = r_done;
    w_trunc_nxt      = r_trunc;
    w_cnt_nxt        = r_cnt;

    if (bus.load_valid) begin
      w_row_nxt   = bus.load_row;
      w_col_nxt   = bus.load_col;
      w_pass_nxt  = bus.load_pass;
      w_dest_nxt  = bus.load_dest;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_trunc_nxt = 1'b0;
      w_state_nxt = S_RUN;
    end else if (bus.start) begin
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_trunc_nxt = 1'b0;
      w_state_nxt = S_GEN;
    end else begin
      case (r_state)
        S_GEN: begin
          if (w_gen_ok) begin
            w_row_nxt   = w_lfsr[2:0];
            w_col_nxt   = w_lfsr[5:3];
            w_pass_nxt  = {1'b0, w_lfsr[7:6]};
            w_dest_nxt  = w_lfsr[9:8];
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.act_valid) begin
            w_step_valid_nxt = 1'b1;
            w_cnt_nxt        = w_cnt_inc;
            w_reward_nxt     = R_STEP;
            case (bus.act)
              ACT_SOUTH: if (r_row < GRID_MAX) w_row_nxt = r_row + 3'd1;
              ACT_NORTH: if (r_row != 3'd0) w_row_nxt = r_row - 3'd1;
              ACT_EAST:  if (!east_wall(r_row, r_col)) w_col_nxt = r_col + 3'd1;
              ACT_WEST:  if (!west_wall(r_row, r_col)) w_col_nxt = r_col - 3'd1;
              ACT_PICKUP: begin
                if (r_pass < PASS_IN_TAXI && w_land == r_pass) w_pass_nxt = PASS_IN_TAXI;
                else w_reward_nxt = R_ILLEGAL;
              end
              ACT_DROPOFF: begin
                if (r_pass == PASS_IN_TAXI && w_land == {1'b0, r_dest}) begin
                  w_pass_nxt   = w_land;
                  w_reward_nxt = R_GOAL;
                  w_done_nxt   = 1'b1;
                end else if (r_pass == PASS_IN_TAXI && w_land != PASS_IN_TAXI) begin
                  w_pass_nxt = w_land;
                end else begin
                  w_reward_nxt = R_ILLEGAL;
                end
              end
              default: ;
            endcase
            if (w_cnt_inc >= CNT_W'(MAX_STEPS)) w_trunc_nxt = 1'b1;
            if (w_done_nxt || w_trunc_nxt) w_state_nxt = S_END;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.act_ready  = (r_state == S_RUN);
  assign bus.taxi_row   = r_row;
  assign bus.taxi_col   = r_col;
  assign bus.pass_loc   = r_pass;
  assign bus.dest_idx   = r_dest;
  assign bus.step_valid = r_step_valid;
  assign bus.reward     = r_reward;
  assign bus.done       = r_done;
  assign bus.truncated  = r_trunc;
  assign bus.step_count = r_cnt;
endmodule

// File: tb/tb_taxi_env_step.sv
// Directed bench for taxi_env_step with hand-computed expectations.
module tb_taxi_env_step;
  import taxi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  taxi_env_step_if bus ();

  taxi_env_step #(.MAX_STEPS(3), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input int c, input int p, input int d);
    bus.load_valid = 1'b1;
    bus.load_row   = 3'(r);
    bus.load_col   = 3'(c);
    bus.load_pass  = 3'(p);
    bus.load_dest  = 2'(d);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic step(input logic [2:0] a);
    bus.act_valid = 1'b1;
    bus.act       = a;
    tick();
    bus.act_valid = 1'b0;
  endtask

  function automatic int encode(input int r, input int c, input int p, input int d);
    return ((r * 5 + c) * 5 + p) * 4 + d;
  endfunction

  initial begin
    bit found;
    rst = 1'b1;
    bus.load_valid = 1'b0; bus.load_row = '0; bus.load_col = '0; bus.load_pass = '0;
    bus.load_dest = '0; bus.start = 1'b0; bus.act_valid = 1'b0; bus.act = '0;
    tick(); tick();
    check("rst_row", bus.taxi_row, 0);
    check("rst_pass", bus.pass_loc, 0);
    check("rst_ready", bus.act_ready, 0);
    check("rst_sv", bus.step_valid, 0);
    check("rst_rew_cnt", {bus.reward, bus.step_count, bus.done, bus.truncated}, 0);
    rst = 1'b0;
    tick();
    check("idle_ready", bus.act_ready, 0);

    load(1, 0, 2, 3);
    check("ld_ready", bus.act_ready, 1);
    check("ld_encode", encode(int'(bus.taxi_row), int'(bus.taxi_col),
                              int'(bus.pass_loc), int'(bus.dest_idx)), 111);

    load(0, 1, 2, 3);
    step(ACT_EAST);
    check("wall_col", bus.taxi_col, 1);
    check("wall_rew", bus.reward, 6'h3F);
    check("wall_sv", bus.step_valid, 1);
    check("wall_cnt", bus.step_count, 1);
    tick();
    check("wall_sv_pulse", bus.step_valid, 0);
    check("wall_rew_hold", bus.reward, 6'h3F);
    step(ACT_SOUTH);
    check("south_row", bus.taxi_row, 1);
    check("south_cnt", bus.step_count, 2);

    load(3, 3, 0, 1);
    step(ACT_WEST);
    check("west_wall_col", bus.taxi_col, 3);
    load(2, 2, 0, 1);
    step(ACT_EAST);
    check("east_open_col", bus.taxi_col, 3);
    step(ACT_NORTH);
    check("north_row", bus.taxi_row, 1);

    load(4, 0, 2, 3);
    step(ACT_PICKUP);
    check("pick_pass", bus.pass_loc, 4);
    check("pick_rew", bus.reward, 6'h3F);
    step(ACT_PICKUP);
    check("pick2_rew", bus.reward, 6'h36);
    check("pick2_pass", bus.pass_loc, 4);

    load(0, 0, 4, 3);
    step(ACT_DROPOFF);
    check("drop_other_pass", bus.pass_loc, 0);
    check("drop_other_rew", bus.reward, 6'h3F);
    check("drop_other_done", bus.done, 0);
    load(1, 1, 4, 0);
    step(ACT_DROPOFF);
    check("drop_none_rew", bus.reward, 6'h36);
    check("drop_none_pass", bus.pass_loc, 4);
    step(7);
    check("act7_rew", bus.reward, 6'h3F);
    check("act7_cnt", bus.step_count, 2);

    load(4, 3, 4, 3);
    step(ACT_DROPOFF);
    check("goal_pass", bus.pass_loc, 3);
    check("goal_rew", bus.reward, 6'h14);
    check("goal_done", bus.done, 1);
    check("goal_ready", bus.act_ready, 0);
    step(ACT_NORTH);
    tick();
    check("end_row", bus.taxi_row, 4);
    check("end_cnt", bus.step_count, 1);
    check("end_sv", bus.step_valid, 0);
    check("end_done", bus.done, 1);

    load(0, 0, 1, 2);
    step(ACT_NORTH);
    step(ACT_NORTH);
    check("trunc_early", bus.truncated, 0);
    step(ACT_NORTH);
    check("trunc_flag", bus.truncated, 1);
    check("trunc_done", bus.done, 0);
    check("trunc_ready", bus.act_ready, 0);
    check("trunc_cnt", bus.step_count, 3);
    check("trunc_row", bus.taxi_row, 0);

    load(2, 2, 0, 1);
    bus.act_valid = 1'b1;
    bus.act = ACT_SOUTH;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.act_valid = 1'b0;
    check("midrst_ready", bus.act_ready, 0);
    check("midrst_row", bus.taxi_row, 0);
    check("midrst_sv", bus.step_valid, 0);

    for (int ep = 0; ep < 100; ep++) begin
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 64 && !found; c++) begin
        if (bus.act_ready) found = 1'b1;
        else tick();
      end
      check("rand_ready", found, 1);
      if (found) begin
        check("rand_row", bus.taxi_row < 5, 1);
        check("rand_col", bus.taxi_col < 5, 1);
        check("rand_pass", bus.pass_loc < 4, 1);
        check("rand_dest", bus.dest_idx != bus.pass_loc[1:0], 1);
        check("rand_cnt", bus.step_count, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
